// File: rtl/dm_cache_wb_if.sv
// Requester and line-memory signal bundle for dm_cache_wb.
// The slave modport is the cache's view; the master modport is the requester/memory view.
interface dm_cache_wb_if #(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDRESS_SIZE   = 32
);
  localparam int LINE_W = WORD_SIZE * WORDS_PER_LINE;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0]    req_wdata;
  logic                    resp_valid;
  logic [WORD_SIZE-1:0]    resp_rdata;
  logic                    resp_hit;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [LINE_W-1:0]       mem_wdata;
  logic [LINE_W-1:0]       mem_rdata;
  logic                    mem_ack;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_wb.sv
// Direct-mapped write-back/write-allocate cache: one request at a time, dirty victims
// are written back and lines refilled through a req/ack line-wide memory port.
module dm_cache_wb #(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_LINES      = 4,
  parameter int ADDRESS_SIZE   = 32
) (
  input logic          clk,
  input logic          rst,
  dm_cache_wb_if.slave bus
);
  localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = ADDRESS_SIZE - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  state_t state, state_nxt;

  logic                    we_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic                    miss_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [NUM_LINES-1:0]    dirty_q;
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0]    data_q [NUM_LINES][WORDS_PER_LINE];

  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_W-1:0]      idx;
  logic [OFFSET_W-1:0]     off;
  logic                    hit;

  assign req_tag = addr_q[ADDRESS_SIZE-1 -: TAG_W];
  assign idx     = addr_q[OFFSET_W +: INDEX_W];
  assign off     = addr_q[OFFSET_W-1:0];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.req_valid) state_nxt = COMPARE;
      COMPARE: begin
        if (hit)                          state_nxt = IDLE;
        else if (valid_q[idx] && dirty_q[idx]) state_nxt = WRITEBACK;
        else                              state_nxt = FILL;
      end
      WRITEBACK: if (bus.mem_ack) state_nxt = FILL;
      FILL:      if (bus.mem_ack) state_nxt = COMPARE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Memory-port outputs come straight from state and the latched request, so they
  // hold steady for the whole transaction and vanish the instant reset hits.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      WRITEBACK: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {tag_q[idx], idx, {OFFSET_W{1'b0}}};
        for (int w = 0; w < WORDS_PER_LINE; w++)
          bus.mem_wdata[w*WORD_SIZE +: WORD_SIZE] = data_q[idx][w];
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, idx, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      miss_q         <= 1'b0;
      valid_q        <= '0;
      dirty_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          miss_q  <= 1'b0;
        end
        COMPARE: begin
          if (hit) begin
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= !miss_q;
            if (we_q) dirty_q[idx]   <= 1'b1;
            else      bus.resp_rdata <= data_q[idx][off];
          end else begin
            miss_q <= 1'b1;
          end
        end
        WRITEBACK: if (bus.mem_ack) dirty_q[idx] <= 1'b0;
        FILL: if (bus.mem_ack) begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && we_q)
      data_q[idx][off] <= wdata_q;
    if (state == FILL && bus.mem_ack) begin
      tag_q[idx] <= req_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++)
        data_q[idx][w] <= bus.mem_rdata[w*WORD_SIZE +: WORD_SIZE];
    end
  end
endmodule

// File: doc/dm_cache_wb.md
Name: dm_cache_wb

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache.
- Sits between a word-addressed requester (CPU/DMA side) and a line-wide backing memory.
- Adds valid/dirty tracking, a ready/valid request handshake, and a miss FSM that writes back dirty victims and refills whole lines through a req/ack memory port.

Parameters:
- WORD_SIZE, 32: bits per word.
- WORDS_PER_LINE, 4: words per cache line; power of two, >= 2.
- NUM_LINES, 4: cache lines; power of two, >= 2.
- ADDRESS_SIZE, 32: word-address width.
- Derived (localparam, not overridable):
  - OFFSET_W = clog2(WORDS_PER_LINE)
  - INDEX_W = clog2(NUM_LINES)
  - TAG_W = ADDRESS_SIZE - OFFSET_W - INDEX_W
  - LINE_W = WORD_SIZE * WORDS_PER_LINE

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  requester presents a request.
- req_ready  output  1  cache can accept a request (high only in IDLE).
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDRESS_SIZE  word address: [OFFSET_W-1:0] offset, next INDEX_W bits index, top TAG_W bits tag.
- req_wdata  input  WORD_SIZE  write data.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_rdata  output  WORD_SIZE  read data; valid with resp_valid on reads.
- resp_hit  output  1  qualified by resp_valid; 1 if the request hit on first lookup.
- mem_req  output  1  memory transaction request; held until mem_ack.
- mem_we  output  1  1 = line writeback, 0 = line fill.
- mem_addr  output  ADDRESS_SIZE  line-aligned address (offset bits 0).
- mem_wdata  output  LINE_W  victim line for writeback; word 0 in LSBs.
- mem_rdata  input  LINE_W  fill data; sampled on the mem_ack cycle.
- mem_ack  input  1  one-cycle completion from memory.

Behaviour:
- Reset (async):
  - State IDLE.
  - All valid and dirty bits cleared; tag and data arrays need not be cleared.
  - req_ready=1.
  - resp_valid, resp_hit, mem_req, mem_we = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
- Reset mid-transaction: any transaction in flight is abandoned and mem_req drops immediately. A late mem_ack after reset is ignored.
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/addr/wdata, clear the first-lookup miss flag, go to COMPARE.
- COMPARE:
  - Hit = valid[index] && tag[index] == latched tag.
  - Read hit: resp_rdata <= word[offset]; resp_valid pulses the cycle after COMPARE, state returns to IDLE.
  - Write hit: replace word[offset] and set dirty[index]; resp_valid pulses, return to IDLE. resp_rdata holds its previous value.
  - resp_hit = 1 unless the miss flag was set earlier in this request.
  - Miss: set the miss flag.
    - If valid && dirty: go to WRITEBACK.
    - Otherwise: go to FILL.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, index, 0}; mem_wdata = victim line.
  - On mem_ack: clear dirty, go to FILL.
- FILL:
  - mem_req=1, mem_we=0.
  - mem_addr = {req tag, index, 0}.
  - On mem_ack: line <= mem_rdata, tag <= req tag, valid=1, dirty=0, go to COMPARE. The re-lookup hits and completes per the hit rules, with resp_hit=0.
- Latency (accept edge = edge 0):
  - Hit: resp_valid high after edge 1 (2 cycles).
  - Clean miss: fill wait + 2 cycles.
  - Dirty miss: writeback wait + fill wait + 2 cycles.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- mem_ack outside WRITEBACK/FILL is ignored.
- No pipelining: one outstanding request; req_ready=0 outside IDLE.
- A request and resp_valid may coincide: resp_valid pulses on the same cycle IDLE is re-entered, and a new request may be accepted on that cycle.

Test Plan:
- Reset, then read 0x05 (index 1, offset 1, tag 0) → mem_req, mem_we=0, mem_addr=0x04. Ack with line {W3..W0} = {0xD,0xC,0xB,0xA} → resp_valid, resp_rdata=0xB, resp_hit=0.
- Read 0x06 → resp_valid exactly 2 cycles after accept, resp_rdata=0xC, resp_hit=1, no mem_req.
- Write 0x05 ← 0x1234, then read 0x15 (same index 1, tag 1):
  - writeback with mem_we=1, mem_addr=0x04, mem_wdata words {0xD,0xC,0x1234,0xA};
  - then fill from mem_addr=0x14; resp_hit=0.
- Re-read 0x05 after the eviction → clean miss: fill only from 0x04, no writeback, since the 0x14 line is clean.
- Assert rst during FILL with mem_req high → mem_req=0 immediately; all lines invalid. The next read of 0x06 misses.
- Hold mem_ack low 10 cycles during FILL → mem_req, mem_addr stable throughout; req_ready=0; a req_valid held high during this time is not accepted.
